// File: rtl/cpu_mem_io.sv
// cpu_mem_io: RAM plus memory-mapped I/O page behind the 16-bit core.
// I/O page at IO_BASE: +0 TXDATA, +1 STATUS, +2 TIMER, +3 RXDATA.
// Optional timer: define CPU_MEM_IO_TIMER_EN to build the timer/prescaler;
// without it TIMER reads 0 and writes to it are ignored.
//
// TX handshake: tx_valid is high whenever the FIFO holds a byte and tx_data
// is the head byte; the byte leaves on a rising edge where tx_valid and
// tx_ready are both high. tx_valid never waits on tx_ready.
module cpu_mem_io #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned IO_BASE   = 12'hFF0,
  parameter int unsigned TX_DEPTH  = 8,
  parameter int unsigned TIMER_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_we,
  output logic [15:0] cpu_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int unsigned PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(IO_BASE);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(IO_BASE + 1);
  localparam logic [ADDR_W-1:0] A_TIMER  = ADDR_W'(IO_BASE + 2);
  localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(IO_BASE + 3);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(TX_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TX_DEPTH - 1);

  // ---------------------------------------------------------------- decode
  logic [ADDR_W-1:0] a;
  logic              is_ram;
  logic              wr_tx;
  logic              wr_status;
  logic              wr_rxdata;
  logic              unused_addr_hi;

  assign a              = cpu_addr[ADDR_W-1:0];
  assign unused_addr_hi = ^cpu_addr[15:ADDR_W];
  assign is_ram         = (a < A_TXDATA);
  assign wr_tx          = cpu_we && (a == A_TXDATA);
  assign wr_status      = cpu_we && (a == A_STATUS);
  assign wr_rxdata      = cpu_we && (a == A_RXDATA);

  // ---------------------------------------------------------------- RAM
  logic [15:0] ram_q [0:IO_BASE-1];

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (cpu_we && is_ram) ram_q[a] <= cpu_wdata;
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]       tx_mem_q [0:TX_DEPTH-1];
  logic [PTR_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [PTR_W-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             tx_ovf_q, tx_ovf_d;
  logic             tx_empty;
  logic             tx_full;
  logic             tx_pop;
  logic             tx_push_ok;

  assign tx_empty   = (tx_cnt_q == '0);
  assign tx_full    = (tx_cnt_q == DEPTH_C);
  assign tx_pop     = !tx_empty && tx_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO is kept
  assign tx_push_ok = wr_tx && (!tx_full || tx_pop);

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_ptr_q];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // FIFO storage write; contents are meaningless until the count covers them
  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem_q[tx_wr_ptr_q] <= cpu_wdata[7:0];
  end

  // FIFO pointer, count and overflow next-state
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    tx_ovf_d    = tx_ovf_q;
    if (tx_push_ok) tx_wr_ptr_d = ptr_inc(tx_wr_ptr_q);
    if (tx_pop)     tx_rd_ptr_d = ptr_inc(tx_rd_ptr_q);
    case ({tx_push_ok, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
    if (wr_status) tx_ovf_d = 1'b0;
    if (wr_tx && tx_full && !tx_pop) tx_ovf_d = 1'b1;
  end

  // FIFO control registers; reset flushes the FIFO at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      tx_ovf_q    <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_ovf_q    <= tx_ovf_d;
    end
  end

  // ---------------------------------------------------------------- RX
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_full_q, rx_full_d;
  logic       rx_ovr_q, rx_ovr_d;

  // RX capture: a new byte always wins over a CPU clear on the same edge
  always_comb begin
    rx_byte_d = rx_byte_q;
    rx_full_d = rx_full_q;
    rx_ovr_d  = rx_ovr_q;
    if (wr_rxdata) rx_full_d = 1'b0;
    if (wr_status) rx_ovr_d  = 1'b0;
    if (rx_valid) begin
      rx_byte_d = rx_data;
      rx_full_d = 1'b1;
      if (rx_full_q) rx_ovr_d = 1'b1;
    end
  end

  // RX registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte_q <= 8'h00;
      rx_full_q <= 1'b0;
      rx_ovr_q  <= 1'b0;
    end else begin
      rx_byte_q <= rx_byte_d;
      rx_full_q <= rx_full_d;
      rx_ovr_q  <= rx_ovr_d;
    end
  end

  // ---------------------------------------------------------------- timer
  logic [15:0] timer_val;

`ifdef CPU_MEM_IO_TIMER_EN
  localparam logic [15:0] PRE_LAST = 16'(TIMER_DIV - 1);

  logic        wr_timer;
  logic [15:0] timer_q, timer_d;
  logic [15:0] pre_q, pre_d;

  assign wr_timer  = cpu_we && (a == A_TIMER);
  assign timer_val = timer_q;

  // Timer next-state: CPU load beats the prescaled increment
  always_comb begin
    timer_d = timer_q;
    pre_d   = pre_q;
    if (wr_timer) begin
      timer_d = cpu_wdata;
      pre_d   = '0;
    end else if (pre_q == PRE_LAST) begin
      timer_d = timer_q + 16'd1;
      pre_d   = '0;
    end else begin
      pre_d = pre_q + 16'd1;
    end
  end

  // Timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      pre_q   <= '0;
    end else begin
      timer_q <= timer_d;
      pre_q   <= pre_d;
    end
  end
`else
  logic unused_timer_cfg;

  assign unused_timer_cfg = (TIMER_DIV == 0);
  assign timer_val        = 16'h0000;
`endif

  // ---------------------------------------------------------------- read mux
  logic [15:0] status;
  logic [3:0]  status_cnt;

  // Only four count bits fit the STATUS field; a full 16-deep FIFO is
  // still visible through tx_full.
  assign status_cnt = 4'(tx_cnt_q);
  assign status     = {4'h0, status_cnt, 3'b000,
                       rx_full_q, rx_ovr_q, tx_ovf_q, tx_empty, tx_full};

  // Combinational read data for the current address
  always_comb begin
    cpu_rdata = 16'h0000;
    if (is_ram) begin
      cpu_rdata = ram_q[a];
    end else begin
      case (a)
        A_STATUS: cpu_rdata = status;
        A_TIMER:  cpu_rdata = timer_val;
        A_RXDATA: cpu_rdata = {8'h00, rx_byte_q};
        default:  cpu_rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_io.sv
// tb_cpu_mem_io: directed checks of the documented scenarios plus a
// randomized run compared against a queue/array model of the I/O page.
module tb_cpu_mem_io;

  localparam int IO_BASE   = 'hFF0;
  localparam int TX_DEPTH  = 8;
  localparam int TIMER_DIV = 1;

  localparam logic [15:0] A_TX = 16'h0FF0;
  localparam logic [15:0] A_ST = 16'h0FF1;
  localparam logic [15:0] A_TM = 16'h0FF2;
  localparam logic [15:0] A_RX = 16'h0FF3;
  localparam logic [15:0] A_NO = 16'h0FF9;

  // ------------------------------------------------------------ clock/reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_addr = A_NO;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;

  always #5 clk = ~clk;

  cpu_mem_io #(
    .ADDR_W(12), .IO_BASE(IO_BASE), .TX_DEPTH(TX_DEPTH), .TIMER_DIV(TIMER_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  // ------------------------------------------------------------ model state
  logic [7:0]  exp_q[$];
  logic [15:0] ram_m [int];
  bit          m_tx_ovf, m_rx_ovr, m_rx_full;
  logic [7:0]  m_rx_byte;
  logic [15:0] m_timer;
  int          m_pre;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_tx_ovf  = 0;
    m_rx_ovr  = 0;
    m_rx_full = 0;
    m_rx_byte = 8'h00;
    m_timer   = 16'h0000;
    m_pre     = 0;
  endtask

  function automatic logic [15:0] m_status();
    int sz;
    logic e, f;
    sz = exp_q.size();
    e  = (sz == 0);
    f  = (sz == TX_DEPTH);
    return {4'h0, 4'(sz), 3'b000, m_rx_full, m_rx_ovr, m_tx_ovf, e, f};
  endfunction

  // Expected read value; returns 0 when the RAM word was never written.
  function automatic bit m_read(input logic [15:0] addr, output logic [15:0] val);
    int a;
    a   = int'(addr[11:0]);
    val = 16'h0000;
    if (a < IO_BASE) begin
      if (!ram_m.exists(a)) return 0;
      val = ram_m[a];
    end else if (a == IO_BASE + 1) begin
      val = m_status();
    end else if (a == IO_BASE + 2) begin
`ifdef CPU_MEM_IO_TIMER_EN
      val = m_timer;
`else
      val = 16'h0000;
`endif
    end else if (a == IO_BASE + 3) begin
      val = {8'h00, m_rx_byte};
    end
    return 1;
  endfunction

  // Apply one rising edge's worth of architectural effects to the model.
  task automatic model_edge();
    int a;
    bit pop, full;
    a    = int'(cpu_addr[11:0]);
    pop  = (exp_q.size() > 0) && tx_ready;
    full = (exp_q.size() == TX_DEPTH);
    if (cpu_we && a < IO_BASE) ram_m[a] = cpu_wdata;
    if (pop) void'(exp_q.pop_front());
    if (cpu_we && a == IO_BASE) begin
      if (!full || pop) exp_q.push_back(cpu_wdata[7:0]);
      else m_tx_ovf = 1;
    end
    if (cpu_we && a == IO_BASE + 1) begin
      m_tx_ovf = 0;
      m_rx_ovr = 0;
    end
    if (rx_valid && m_rx_full) m_rx_ovr = 1;
    if (cpu_we && a == IO_BASE + 3) m_rx_full = 0;
    if (rx_valid) begin
      m_rx_full = 1;
      m_rx_byte = rx_data;
    end
    if (cpu_we && a == IO_BASE + 2) begin
      m_timer = cpu_wdata;
      m_pre   = 0;
    end else begin
      m_pre++;
      if (m_pre == TIMER_DIV) begin
        m_pre   = 0;
        m_timer = m_timer + 16'd1;
      end
    end
  endtask

  // ------------------------------------------------------------ driver tasks
  task automatic drive(input logic [15:0] addr, input logic [15:0] wd, input bit we,
                       input bit rdy, input bit rxv, input logic [7:0] rxd);
    cpu_addr  = addr;
    cpu_wdata = wd;
    cpu_we    = we;
    tx_ready  = rdy;
    rx_valid  = rxv;
    rx_data   = rxd;
  endtask

  // Check outputs against the model, then advance one clock.
  task automatic cycle(input string tag);
    logic [15:0] v;
    bit known;
    #1;
    known = m_read(cpu_addr, v);
    if (known) check({tag, "_rdata"}, cpu_rdata, v);
    check({tag, "_txvalid"}, {15'b0, tx_valid}, {15'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) check({tag, "_txdata"}, {8'h00, tx_data}, {8'h00, exp_q[0]});
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Directed read with an explicit constant expectation (consumes a cycle).
  task automatic peek(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    drive(addr, 16'h0000, 0, tx_ready, 0, 8'h00);
    #1;
    check(tag, cpu_rdata, exp);
    cycle(tag);
  endtask

  // ------------------------------------------------------------ stimulus
  logic [7:0] drain_exp [0:7];
  logic [11:0] ra;

  initial begin
    model_reset();
    drive(A_ST, 0, 0, 0, 0, 8'h00);
    #2;
    check("rst_txvalid", {15'b0, tx_valid}, 16'h0000);
    check("rst_txdata", {8'h00, tx_data}, 16'h0000);
    check("rst_status", cpu_rdata, 16'h0002);
    cpu_addr = A_TM; #1;
    check("rst_timer", cpu_rdata, 16'h0000);
    cpu_addr = A_RX; #1;
    check("rst_rxdata", cpu_rdata, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // RAM write/read and high-bit aliasing
    drive(16'h0010, 16'hBEEF, 1, 0, 0, 8'h00); cycle("ram_wr");
    peek("ram_rd", 16'h0010, 16'hBEEF);
    peek("ram_alias", 16'hF010, 16'hBEEF);

    // FIFO fill, overflow, drain in order
    for (int i = 0; i < 8; i++) begin
      drive(A_TX, 16'h0041 + 16'(i), 1, 0, 0, 8'h00); cycle("fill");
    end
    peek("fill_status", A_ST, 16'h0801);
    drive(A_TX, 16'h0049, 1, 0, 0, 8'h00); cycle("ovf_push");
    peek("ovf_status", A_ST, 16'h0805);
    for (int i = 0; i < 8; i++) begin
      drive(A_NO, 0, 0, 1, 0, 8'h00);
      #1;
      check("drain_order", {8'h00, tx_data}, 16'h0041 + 16'(i));
      cycle("drain");
    end
    drive(A_ST, 0, 0, 1, 0, 8'h00);
    #1;
    check("drain_empty", {15'b0, tx_valid}, 16'h0000);
    check("drain_status", cpu_rdata, 16'h0006);
    drive(A_ST, 16'hFFFF, 1, 0, 0, 8'h00); cycle("clr_ovf");

    // Push into a full FIFO on the same edge as a pop
    for (int i = 0; i < 8; i++) begin
      drive(A_TX, 16'h0060 + 16'(i), 1, 0, 0, 8'h00); cycle("fill2");
    end
    drive(A_TX, 16'h0055, 1, 1, 0, 8'h00); cycle("push_pop");
    tx_ready = 1'b0;
    peek("push_pop_status", A_ST, 16'h0801);
    for (int i = 0; i < 7; i++) drain_exp[i] = 8'h61 + 8'(i);
    drain_exp[7] = 8'h55;
    for (int i = 0; i < 8; i++) begin
      drive(A_NO, 0, 0, 1, 0, 8'h00);
      #1;
      check("push_pop_order", {8'h00, tx_data}, {8'h00, drain_exp[i]});
      cycle("drain2");
    end

    // RX capture, overrun, clears
    drive(A_NO, 0, 0, 0, 1, 8'h3C); cycle("rx1");
    peek("rx1_data", A_RX, 16'h003C);
    peek("rx1_status", A_ST, 16'h0012);
    drive(A_NO, 0, 0, 0, 1, 8'h7E); cycle("rx2");
    peek("rx2_data", A_RX, 16'h007E);
    peek("rx2_status", A_ST, 16'h001A);
    drive(A_ST, 16'h0000, 1, 0, 0, 8'h00); cycle("clr_ovr");
    peek("clr_ovr_status", A_ST, 16'h0012);
    drive(A_RX, 16'h0000, 1, 0, 1, 8'hA5); cycle("rx_vs_clr");
    peek("rx_vs_clr_status", A_ST, 16'h001A);
    drive(A_RX, 16'h0000, 1, 0, 0, 8'h00); cycle("clr_full");
    drive(A_ST, 16'h0000, 1, 0, 0, 8'h00); cycle("clr_ovr2");
    peek("clr_full_status", A_ST, 16'h0002);

    // Timer wrap
    drive(A_TM, 16'hFFFE, 1, 0, 0, 8'h00); cycle("tmr_wr");
    repeat (3) begin
      drive(A_NO, 0, 0, 0, 0, 8'h00); cycle("tmr_wait");
    end
`ifdef CPU_MEM_IO_TIMER_EN
    peek("tmr_wrap", A_TM, 16'h0001);
`else
    peek("tmr_absent", A_TM, 16'h0000);
`endif

    // Randomized run against the model
    for (int i = 0; i < 32; i++) begin
      drive(16'h0020 + 16'(i), 16'($urandom), 1, 0, 0, 8'h00); cycle("ram_init");
    end
    for (int i = 0; i < 400; i++) begin
      int sel;
      bit we;
      sel = $urandom_range(0, 6);
      case (sel)
        0: ra = A_TX[11:0];
        1: ra = A_ST[11:0];
        2: ra = A_TM[11:0];
        3: ra = A_RX[11:0];
        4: ra = 12'hFF4 + 12'($urandom_range(0, 11));
        default: ra = 12'h020 + 12'($urandom_range(0, 31));
      endcase
      we = (sel == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      drive({4'($urandom), ra}, 16'($urandom), we, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0, 8'($urandom));
      cycle("rand");
    end

    // Asynchronous reset mid-cycle with bytes queued
    drive(A_ST, 0, 1, 0, 0, 8'h00); cycle("clr_before_rst");
    for (int i = 0; i < 3; i++) begin
      drive(A_TX, 16'h0070 + 16'(i), 1, 0, 0, 8'h00); cycle("rst_fill");
    end
    drive(A_ST, 0, 0, 1, 0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_txvalid", {15'b0, tx_valid}, 16'h0000);
    check("arst_status", cpu_rdata, 16'h0002);
    cpu_addr = 16'h0010; #1;
    check("arst_ram", cpu_rdata, 16'hBEEF);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive({4'($urandom), 12'hFF0 + 12'($urandom_range(0, 3))}, 16'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0, 8'($urandom));
      cycle("post_rst");
    end

    // ------------------------------------------------------------ report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
